// File: rtl/procyon_sram_pkg.sv
// procyon_sram_pkg
// Shared definitions for the two-port SRAM arbiter:
//   NUM_PORTS    - number of requester ports
//   PORT_IDX_W   - width of a port index
//   sram_state_t - access FSM states (IDLE, LO half, HI half, ACK)
//   rr_index     - helper to walk ports starting from a priority pointer
package procyon_sram_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_IDX_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } sram_state_t;

    // Port visited at step 'off' of a search that starts at port 'base'.
    function automatic int rr_index(input int base, input int off);
        return (base + off) % NUM_PORTS;
    endfunction

endpackage

// File: rtl/procyon_sram_arb_rr.sv
// procyon_sram_arb_rr
// Grant selection for the SRAM arbiter.
//   clk, rst  - clock, synchronous active-high reset
//   req       - per-port pending request vector
//   advance   - a grant is being taken this cycle (updates the pointer)
//   grant     - one-hot grant, combinational from req and the pointer
// Build option: define PROCYON_SRAM_ARB_RR_EN for round-robin (the port
// granted last loses a simultaneous request); otherwise the pointer is
// pinned at port 0, giving fixed priority with port 0 winning.
module procyon_sram_arb_rr
    import procyon_sram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef PROCYON_SRAM_ARB_RR_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif

    logic [PORT_IDX_W-1:0] ptr_reg;
    logic [PORT_IDX_W-1:0] ptr_next;
    logic                  hit_next;

    // Search from the pointer; the first requesting port wins and the
    // pointer moves just past it.
    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        hit_next = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[PORT_IDX_W'(rr_index(int'(ptr_reg), i))] && !hit_next) begin
                grant[PORT_IDX_W'(rr_index(int'(ptr_reg), i))] = 1'b1;
                ptr_next = PORT_IDX_W'(rr_index(int'(ptr_reg), i + 1));
                hit_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance && ROTATE) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/procyon_sram_arb.sv
// procyon_sram_arb
// Arbitrates two 32-bit bus ports onto one 16-bit asynchronous SRAM.
// Each 32-bit access is split into a LO and a HI halfword access of
// OPTN_SRAM_WAIT cycles each; halves with no byte enables are skipped.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   i_wbN_cyc/stb/we/addr/sel  - port N request (byte address, [1:0] unused)
//   i_wbN_data / o_wbN_data    - port N write / read data
//   o_wbN_ack                  - port N one-cycle completion pulse
//   o_sram_addr                - SRAM halfword address
//   i_sram_dq / o_sram_dq      - SRAM read / write data, o_sram_dq_oe drives bus
//   o_sram_*_n                 - active-low SRAM strobes
// Build option: PROCYON_SRAM_ARB_RR_EN selects round-robin arbitration
// (see procyon_sram_arb_rr); undefined gives fixed priority to port 0.
module procyon_sram_arb
    import procyon_sram_pkg::*;
#(
    parameter int OPTN_WB_DATA_WIDTH   = 32,
    parameter int OPTN_SRAM_ADDR_WIDTH = 20,
    parameter int OPTN_SRAM_DATA_WIDTH = 16,
    parameter int OPTN_SRAM_WAIT       = 2
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wb0_cyc,
    input  logic                            i_wb0_stb,
    input  logic                            i_wb0_we,
    input  logic [OPTN_SRAM_ADDR_WIDTH:0]   i_wb0_addr,
    input  logic [3:0]                      i_wb0_sel,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb0_data,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_wb0_data,
    output logic                            o_wb0_ack,
    input  logic                            i_wb1_cyc,
    input  logic                            i_wb1_stb,
    input  logic                            i_wb1_we,
    input  logic [OPTN_SRAM_ADDR_WIDTH:0]   i_wb1_addr,
    input  logic [3:0]                      i_wb1_sel,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]   i_wb1_data,
    output logic [OPTN_WB_DATA_WIDTH-1:0]   o_wb1_data,
    output logic                            o_wb1_ack,
    output logic [OPTN_SRAM_ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [OPTN_SRAM_DATA_WIDTH-1:0] i_sram_dq,
    output logic [OPTN_SRAM_DATA_WIDTH-1:0] o_sram_dq,
    output logic                            o_sram_dq_oe,
    output logic                            o_sram_ce_n,
    output logic                            o_sram_oe_n,
    output logic                            o_sram_we_n,
    output logic                            o_sram_ub_n,
    output logic                            o_sram_lb_n
);

    localparam int AW = OPTN_SRAM_ADDR_WIDTH;
    localparam int DW = OPTN_SRAM_DATA_WIDTH;
    localparam int WW = OPTN_WB_DATA_WIDTH;
    localparam int CW = $clog2(OPTN_SRAM_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(OPTN_SRAM_WAIT - 1);

    // Per-port views of the request ports
    logic [NUM_PORTS-1:0] cyc_vec, stb_vec, we_vec, req_vec, grant_vec;
    logic [AW-2:0]        word_vec  [NUM_PORTS];
    logic [3:0]           sel_vec   [NUM_PORTS];
    logic [WW-1:0]        wdata_vec [NUM_PORTS];
    logic                 unused_addr_bits;

    assign cyc_vec      = {i_wb1_cyc, i_wb0_cyc};
    assign stb_vec      = {i_wb1_stb, i_wb0_stb};
    assign we_vec       = {i_wb1_we,  i_wb0_we};
    assign word_vec[0]  = i_wb0_addr[AW:2];
    assign word_vec[1]  = i_wb1_addr[AW:2];
    assign sel_vec[0]   = i_wb0_sel;
    assign sel_vec[1]   = i_wb1_sel;
    assign wdata_vec[0] = i_wb0_data;
    assign wdata_vec[1] = i_wb1_data;
    assign unused_addr_bits = ^{i_wb0_addr[1:0], i_wb1_addr[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign req_vec[gi] = cyc_vec[gi] & stb_vec[gi];
        end
    endgenerate

    // Latched transaction and FSM state
    sram_state_t           state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [PORT_IDX_W-1:0] port_reg;
    logic                  we_reg;
    logic [AW-2:0]         word_reg;
    logic [3:0]            sel_reg;
    logic [WW-1:0]         wdata_reg;
    logic [DW-1:0]         lo_reg;
    logic                  drop_reg;
    logic [NUM_PORTS-1:0]  ack_reg;
    logic [WW-1:0]         rdata_reg [NUM_PORTS];

    logic                  take_grant;
    logic [PORT_IDX_W-1:0] gnt_idx;
    logic                  access;
    logic                  half_hi;
    logic                  last_cycle;
    logic                  finish;
    logic                  deliver;
    logic [1:0]            lane_sel;
    logic [DW-1:0]         lo_val;
    logic [DW-1:0]         hi_val;

    assign take_grant = (state_reg == ST_IDLE) && (|req_vec);

    procyon_sram_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (take_grant),
        .grant   (grant_vec)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_vec[i]) begin
                gnt_idx = PORT_IDX_W'(i);
            end
        end
    end

    // Strobes are gated by rst in the same cycle so an access interrupted
    // by reset never starts writing the half that was in progress.
    assign access     = ((state_reg == ST_LO) || (state_reg == ST_HI)) && !rst;
    assign half_hi    = (state_reg == ST_HI);
    assign lane_sel   = half_hi ? sel_reg[3:2] : sel_reg[1:0];
    assign last_cycle = (cnt_reg == CNT_LAST);
    // Last cycle of the last half that is actually accessed
    assign finish     = last_cycle && (half_hi ||
                        ((state_reg == ST_LO) && (sel_reg[3:2] == 2'b00)));
    // A port that dropped cyc at any point gets no ack
    assign deliver    = !drop_reg && cyc_vec[port_reg];
    assign lo_val     = (state_reg == ST_LO) ? i_sram_dq : lo_reg;
    assign hi_val     = half_hi ? i_sram_dq : '0;

    assign o_sram_addr  = access ? {word_reg, half_hi} : '0;
    assign o_sram_dq    = (access && we_reg) ?
                          (half_hi ? wdata_reg[2*DW-1:DW] : wdata_reg[DW-1:0]) : '0;
    assign o_sram_dq_oe = access && we_reg;
    assign o_sram_ce_n  = ~access;
    assign o_sram_oe_n  = ~(access && !we_reg);
    // we_n rises one cycle before the half ends so data is held past the edge
    assign o_sram_we_n  = ~(access && we_reg && !last_cycle);
    assign o_sram_ub_n  = ~(access && lane_sel[1]);
    assign o_sram_lb_n  = ~(access && lane_sel[0]);

    assign o_wb0_ack  = ack_reg[0];
    assign o_wb1_ack  = ack_reg[1];
    assign o_wb0_data = rdata_reg[0];
    assign o_wb1_data = rdata_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            port_reg  <= '0;
            we_reg    <= 1'b0;
            word_reg  <= '0;
            sel_reg   <= '0;
            wdata_reg <= '0;
            lo_reg    <= '0;
            drop_reg  <= 1'b0;
            ack_reg   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            ack_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (take_grant) begin
                        port_reg  <= gnt_idx;
                        we_reg    <= we_vec[gnt_idx];
                        word_reg  <= word_vec[gnt_idx];
                        sel_reg   <= sel_vec[gnt_idx];
                        wdata_reg <= wdata_vec[gnt_idx];
                        lo_reg    <= '0;
                        drop_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        if (sel_vec[gnt_idx][1:0] != 2'b00) begin
                            state_reg <= ST_LO;
                        end else if (sel_vec[gnt_idx][3:2] != 2'b00) begin
                            state_reg <= ST_HI;
                        end else begin
                            // No lanes enabled: complete without touching SRAM
                            state_reg        <= ST_ACK;
                            ack_reg[gnt_idx] <= 1'b1;
                            if (!we_vec[gnt_idx]) begin
                                rdata_reg[gnt_idx] <= '0;
                            end
                        end
                    end
                end
                ST_LO, ST_HI: begin
                    if (!cyc_vec[port_reg]) begin
                        drop_reg <= 1'b1;
                    end
                    if (last_cycle) begin
                        cnt_reg <= '0;
                        if ((state_reg == ST_LO) && !we_reg) begin
                            lo_reg <= i_sram_dq;
                        end
                        if (finish) begin
                            state_reg <= ST_ACK;
                            if (deliver) begin
                                ack_reg[port_reg] <= 1'b1;
                                if (!we_reg) begin
                                    rdata_reg[port_reg] <= {hi_val, lo_val};
                                end
                            end
                        end else begin
                            state_reg <= ST_HI;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_ACK: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/procyon_sram_arb.md
PROCYON_SRAM_ARB -- requirements
Module: procyon_sram_arb

Interface
REQ-001 Parameter OPTN_WB_DATA_WIDTH, default 32: requester data width, fixed at 32.
REQ-002 Parameter OPTN_SRAM_ADDR_WIDTH, default 20: SRAM halfword address width.
REQ-003 Parameter OPTN_SRAM_DATA_WIDTH, default 16: SRAM data width.
REQ-004 Parameter OPTN_SRAM_WAIT, default 2 (minimum 2): cycles per SRAM halfword access.
REQ-005 Ports, one per line, name direction width meaning:
  clk  input  1  clock, single domain
  rst  input  1  reset, synchronous, active-high
  i_wbN_cyc  input  1  port N (N=0,1) bus cycle active
  i_wbN_stb  input  1  port N request strobe
  i_wbN_we  input  1  port N write
  i_wbN_addr  input  OPTN_SRAM_ADDR_WIDTH+1  port N byte address, bits [1:0] ignored
  i_wbN_sel  input  4  port N byte enables
  i_wbN_data  input  32  port N write data
  o_wbN_data  output  32  port N read data
  o_wbN_ack  output  1  port N one-cycle completion pulse
  o_sram_addr  output  OPTN_SRAM_ADDR_WIDTH  SRAM halfword address
  i_sram_dq  input  16  SRAM read data
  o_sram_dq  output  16  SRAM write data
  o_sram_dq_oe  output  1  drive o_sram_dq onto the bus
  o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  output  1 each  SRAM strobes, active-low

Function
REQ-006 Request from port N pending when i_wbN_cyc & i_wbN_stb.
REQ-007 FSM states IDLE, LO, HI, ACK; exactly one transaction in flight.
REQ-008 IDLE: on any pending request, grant one port, latch its we/addr/sel/data, go to LO (or HI/ACK per REQ-011); grant cycle = cycle 0.
REQ-009 LO accesses halfword {addr[20:2],1'b0} with lanes sel[1:0]; HI accesses {addr[20:2],1'b1} with sel[3:2]; ub_n = ~sel upper bit, lb_n = ~sel lower bit of the half.
REQ-010 Each half lasts exactly OPTN_SRAM_WAIT cycles: ce_n low all cycles; read: oe_n low all cycles, i_sram_dq captured in the last cycle; write: we_n low all but the last cycle, o_sram_dq_oe high all cycles.
REQ-011 A half whose two sel bits are both zero is skipped; sel==4'b0000 goes IDLE->ACK with no SRAM access.
REQ-012 ACK: o_wbN_ack high one cycle for granted port, o_wbN_data = {HI data, LO data} (skipped half reads 16'h0); next state IDLE.
REQ-013 Full read/write latency: ack in cycle 2*OPTN_SRAM_WAIT+1 after grant; minimum one IDLE cycle between consecutive transactions.
REQ-014 Granted port dropping cyc mid-transaction: SRAM access completes (no torn write), ack suppressed.
REQ-015 Outside LO/HI: ce_n, oe_n, we_n, ub_n, lb_n high, o_sram_dq_oe low.
REQ-016 o_wbN_data holds last value until next ack to that port.

Reset
REQ-017 rst in any cycle, including mid-access, forces IDLE next cycle; all SRAM strobes high, o_sram_dq_oe 0, o_sram_addr 0, o_sram_dq 0, acks 0, o_wbN_data 0, round-robin pointer favouring port 0; no ack for the aborted transaction.

Configuration
REQ-018 Macro PROCYON_SRAM_ARB_RR_EN defined: round-robin, port last granted loses a simultaneous request.
REQ-019 Macro undefined: fixed priority, port 0 always wins simultaneous requests.

Structure
REQ-020 FSM state enum typedef and port-count constant reside in shared package procyon_sram_pkg.
REQ-021 Grant logic is sub-module procyon_sram_arb_rr (request vector in, one-hot grant out, pointer update on grant).

Verification (OPTN_SRAM_WAIT=2)
REQ-022 Port 0 write addr 0x10, sel 4'hF, data 0xDEADBEEF -> cycles 1-2 addr 0x8 dq 0xBEEF, cycles 3-4 addr 0x9 dq 0xDEAD, we_n low cycles 1 and 3 only, ack cycle 5.
REQ-023 Port 1 read addr 0x10 after REQ-022 -> o_wb1_data 0xDEADBEEF with ack in cycle 5.
REQ-024 Read sel 4'hC addr 0x10 -> only HI accessed (cycles 1-2), ack cycle 3, data 0xDEAD0000; sel 4'h0 -> ack cycle 1, no strobes.
REQ-025 Both ports requesting continuously for 4 transactions -> RR_EN: grants 0,1,0,1; undefined: 0,0,0,0.
REQ-026 rst asserted cycle 3 of a write -> next cycle all strobes high, no ack; subsequent read returns new LO half, HI unchanged.
